// File: rtl/source_arbiter_pkg.sv
// Shared source/tag constants and arbiter FSM encoding.
// The framer imports the tag map from here as well.
package source_arbiter_pkg;

    localparam int SRC_N     = 5;
    localparam int SRC_TAG_W = 3;

    localparam int IDX_DIN   = 0;
    localparam int IDX_ADC0  = 1;
    localparam int IDX_ADC1  = 2;
    localparam int IDX_CADC0 = 3;
    localparam int IDX_CADC1 = 4;

    // Tag 0 is reserved for the frame marker.
    localparam logic [SRC_TAG_W-1:0] TAG_MARK  = 3'd0;
    localparam logic [SRC_TAG_W-1:0] TAG_DIN   = 3'd1;
    localparam logic [SRC_TAG_W-1:0] TAG_ADC0  = 3'd2;
    localparam logic [SRC_TAG_W-1:0] TAG_ADC1  = 3'd3;
    localparam logic [SRC_TAG_W-1:0] TAG_CADC0 = 3'd4;
    localparam logic [SRC_TAG_W-1:0] TAG_CADC1 = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/source_arbiter_rr_pick.sv
// Masked round-robin search: first set req bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic          found;
        logic [IW:0]   s;
        logic [IW-1:0] j;
        found  = 1'b0;
        s      = '0;
        j      = '0;
        onehot = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + (IW+1)'(k);
            if (s >= (IW+1)'(N))
                s = s - (IW+1)'(N);
            j = s[IW-1:0];
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/source_arbiter.sv
// Two-class round-robin source scheduler with bounded bursts
// feeding the packet framer one grant at a time.
module source_arbiter
    import source_arbiter_pkg::*;
#(
    parameter int N_SRC     = SRC_N,
    parameter int MAX_BURST = 4,
    parameter int TAG_W     = SRC_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] em,
    input  logic [N_SRC-1:0] en_mask,
    input  logic [N_SRC-1:0] hi_mask,
    output logic             gnt_valid,
    output logic [TAG_W-1:0] gnt_tag,
    output logic [N_SRC-1:0] gnt_onehot,
    input  logic             gnt_ack,
    input  logic             done,
    output logic             busy,
    output logic [15:0]      grant_cnt
);

    localparam int IW = $clog2(N_SRC);
    localparam int BW = 4;

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cur_idx;
    logic [BW-1:0] burst_cnt;

    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] hi_req;
    logic [N_SRC-1:0] hi_oh;
    logic [N_SRC-1:0] all_oh;
    logic [N_SRC-1:0] win_oh;
    logic [IW-1:0]    hi_idx;
    logic [IW-1:0]    all_idx;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    next_ptr;
    logic             hi_any;
    logic             may_burst;

    assign elig   = ~em & en_mask;
    assign hi_req = elig & hi_mask;
    assign hi_any = |hi_req;

    rr_pick #(.N(N_SRC), .IW(IW)) u_pick_hi (
        .req    (hi_req),
        .ptr    (rr_ptr),
        .onehot (hi_oh),
        .idx    (hi_idx)
    );

    rr_pick #(.N(N_SRC), .IW(IW)) u_pick_all (
        .req    (elig),
        .ptr    (rr_ptr),
        .onehot (all_oh),
        .idx    (all_idx)
    );

    assign win_oh  = hi_any ? hi_oh  : all_oh;
    assign win_idx = hi_any ? hi_idx : all_idx;

    assign next_ptr = (cur_idx == IW'(N_SRC-1))
                    ? '0 : cur_idx + IW'(1);

    // A low-class holder yields as soon as any high-class source waits.
    assign may_burst = elig[cur_idx]
                     && (burst_cnt < BW'(MAX_BURST-1))
                     && !(!hi_mask[cur_idx] && hi_any);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_tag    <= '0;
            gnt_onehot <= '0;
            busy       <= 1'b0;
            grant_cnt  <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            cur_idx    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        state      <= OFFER;
                        gnt_valid  <= 1'b1;
                        gnt_tag    <= TAG_W'(win_idx) + TAG_W'(1);
                        gnt_onehot <= win_oh;
                        cur_idx    <= win_idx;
                    end
                end
                OFFER: begin
                    if (gnt_ack) begin
                        state     <= BUSY;
                        gnt_valid <= 1'b0;
                        busy      <= 1'b1;
                        grant_cnt <= grant_cnt + 16'd1;
                    end
                end
                BUSY: begin
                    if (done) begin
                        busy <= 1'b0;
                        if (may_burst) begin
                            state     <= OFFER;
                            gnt_valid <= 1'b1;
                            burst_cnt <= burst_cnt + BW'(1);
                        end else begin
                            state     <= IDLE;
                            rr_ptr    <= next_ptr;
                            burst_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_source_arbiter.sv
// Bench for source_arbiter: directed scenarios plus a randomized
// run against a behavioural scheduler model (MAX_BURST 4 and 1).
module tb_source_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] em;
    logic [4:0] en_mask;
    logic [4:0] hi_mask;
    logic       gnt_ack;
    logic       done;

    logic        gv   [2];
    logic [2:0]  tag  [2];
    logic [4:0]  oh   [2];
    logic        bsy  [2];
    logic [15:0] cnt  [2];

    int checks;
    int failures;

    // model state per instance: 0 idle, 1 offer, 2 busy
    int ms   [2];
    int mg   [2];
    int mrr  [2];
    int mbc  [2];
    int mcnt [2];

    source_arbiter #(.MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .em         (em),
        .en_mask    (en_mask),
        .hi_mask    (hi_mask),
        .gnt_valid  (gv[0]),
        .gnt_tag    (tag[0]),
        .gnt_onehot (oh[0]),
        .gnt_ack    (gnt_ack),
        .done       (done),
        .busy       (bsy[0]),
        .grant_cnt  (cnt[0])
    );

    source_arbiter #(.MAX_BURST(1)) dut_rr (
        .clk        (clk),
        .rst        (rst),
        .em         (em),
        .en_mask    (en_mask),
        .hi_mask    (hi_mask),
        .gnt_valid  (gv[1]),
        .gnt_tag    (tag[1]),
        .gnt_onehot (oh[1]),
        .gnt_ack    (gnt_ack),
        .done       (done),
        .busy       (bsy[1]),
        .grant_cnt  (cnt[1])
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [4:0] e, logic [4:0] h,
                                int p);
        logic [4:0] c;
        c = ((e & h) != 0) ? (e & h) : e;
        for (int k = 0; k < 5; k++)
            if (c[(p + k) % 5])
                return (p + k) % 5;
        return 0;
    endfunction

    task automatic model_step();
        logic [4:0] el;
        int mb;
        bit higher;
        el = ~em & en_mask;
        for (int u = 0; u < 2; u++) begin
            mb = (u == 0) ? 4 : 1;
            if (rst) begin
                ms[u] = 0; mg[u] = 0; mrr[u] = 0;
                mbc[u] = 0; mcnt[u] = 0;
            end else if (ms[u] == 0) begin
                if (el != 0) begin
                    mg[u] = pick(el, hi_mask, mrr[u]);
                    ms[u] = 1;
                end
            end else if (ms[u] == 1) begin
                if (gnt_ack) begin
                    ms[u] = 2;
                    mcnt[u] = (mcnt[u] + 1) % 65536;
                end
            end else if (done) begin
                higher = !hi_mask[mg[u]] && ((el & hi_mask) != 0);
                if (el[mg[u]] && mbc[u] < mb - 1 && !higher) begin
                    mbc[u]++;
                    ms[u] = 1;
                end else begin
                    mrr[u] = (mg[u] + 1) % 5;
                    mbc[u] = 0;
                    ms[u] = 0;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve();
        gnt_ack = 1'b1;
        step();
        gnt_ack = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gnt_ack = 1'b0;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        em = 5'h1F; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (gv[u] !== 1'b0 || tag[u] !== 3'd0 || oh[u] !== 5'd0
                || bsy[u] !== 1'b0 || cnt[u] !== 16'd0) begin
                failures++;
                $display("FAIL reset u%0d got v=%0b t=%0d oh=%b b=%0b c=%0d exp all 0",
                         u, gv[u], tag[u], oh[u], bsy[u], cnt[u]);
            end
        end
    endtask

    task automatic test_idle_empty();
        em = 5'h1F; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (gv[0] !== 1'b0) begin
                failures++;
                $display("FAIL idle_empty cyc%0d got=%0b exp=0", i, gv[0]);
            end
        end
        em = 5'b11101;
        step();
        checks++;
        if (gv[0] !== 1'b1 || tag[0] !== 3'd2 || oh[0] !== 5'b00010) begin
            failures++;
            $display("FAIL first_grant got v=%0b t=%0d oh=%b exp v=1 t=2 oh=00010",
                     gv[0], tag[0], oh[0]);
        end
    endtask

    task automatic test_rotation();
        int exp_t [6];
        exp_t = '{1, 2, 3, 4, 5, 1};
        em = 5'h00; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (gv[1] !== 1'b1 || tag[1] !== 3'(exp_t[i])) begin
                failures++;
                $display("FAIL rotation #%0d got v=%0b t=%0d exp v=1 t=%0d",
                         i, gv[1], tag[1], exp_t[i]);
            end
            serve();
            step();
        end
        checks++;
        if (cnt[1] !== 16'd6) begin
            failures++;
            $display("FAIL rotation_cnt got=%0d exp=6", cnt[1]);
        end
    endtask

    task automatic test_burst();
        em = 5'b11011; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gv[0] !== 1'b1 || tag[0] !== 3'd3) begin
                failures++;
                $display("FAIL burst #%0d got v=%0b t=%0d exp v=1 t=3",
                         i, gv[0], tag[0]);
            end
            if (i == 1)
                em = 5'b10011;
            serve();
        end
        step();
        checks++;
        if (gv[0] !== 1'b1 || tag[0] !== 3'd4) begin
            failures++;
            $display("FAIL burst_switch got v=%0b t=%0d exp v=1 t=4",
                     gv[0], tag[0]);
        end
        serve();
        checks++;
        if (gv[0] !== 1'b1 || tag[0] !== 3'd4) begin
            failures++;
            $display("FAIL burst_restart got v=%0b t=%0d exp v=1 t=4",
                     gv[0], tag[0]);
        end
    endtask

    task automatic test_hi_class();
        em = 5'b11100; en_mask = 5'h1F; hi_mask = 5'b00001;
        do_reset();
        step();
        for (int i = 0; i < 6; i++) begin
            if (gv[0] !== 1'b1)
                step();
            checks++;
            if (gv[0] !== 1'b1 || tag[0] !== 3'd1) begin
                failures++;
                $display("FAIL hi_din #%0d got v=%0b t=%0d exp v=1 t=1",
                         i, gv[0], tag[0]);
            end
            if (i < 5)
                serve();
        end
        gnt_ack = 1'b1;
        step();
        gnt_ack = 1'b0;
        em = 5'b11101;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++;
        if (gv[0] !== 1'b1 || tag[0] !== 3'd2) begin
            failures++;
            $display("FAIL hi_fallback got v=%0b t=%0d exp v=1 t=2",
                     gv[0], tag[0]);
        end
    endtask

    task automatic test_mask_in_offer();
        em = 5'b10111; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        step();
        em = 5'h1F;
        en_mask = 5'b10111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gv[0] !== 1'b1 || tag[0] !== 3'd4) begin
                failures++;
                $display("FAIL offer_hold #%0d got v=%0b t=%0d exp v=1 t=4",
                         i, gv[0], tag[0]);
            end
        end
        serve();
        em = 5'b10111;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gv[0] !== 1'b0) begin
                failures++;
                $display("FAIL masked_idle #%0d got=%0b exp=0", i, gv[0]);
            end
        end
    endtask

    task automatic test_ack_done_same();
        em = 5'b11110; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        step();
        gnt_ack = 1'b1;
        done = 1'b1;
        step();
        gnt_ack = 1'b0;
        done = 1'b0;
        checks++;
        if (bsy[0] !== 1'b1 || gv[0] !== 1'b0 || cnt[0] !== 16'd1) begin
            failures++;
            $display("FAIL ack_done got b=%0b v=%0b c=%0d exp b=1 v=0 c=1",
                     bsy[0], gv[0], cnt[0]);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (bsy[0] !== 1'b0 || gv[0] !== 1'b1 || tag[0] !== 3'd1) begin
            failures++;
            $display("FAIL min_frame got b=%0b v=%0b t=%0d exp b=0 v=1 t=1",
                     bsy[0], gv[0], tag[0]);
        end
    endtask

    task automatic test_reset_busy();
        em = 5'b11110; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        step();
        gnt_ack = 1'b1;
        step();
        gnt_ack = 1'b0;
        checks++;
        if (bsy[0] !== 1'b1 || cnt[0] !== 16'd1) begin
            failures++;
            $display("FAIL pre_rst got b=%0b c=%0d exp b=1 c=1",
                     bsy[0], cnt[0]);
        end
        em = 5'h1F;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bsy[0] !== 1'b0 || gv[0] !== 1'b0 || cnt[0] !== 16'd0) begin
            failures++;
            $display("FAIL rst_busy got b=%0b v=%0b c=%0d exp 0 0 0",
                     bsy[0], gv[0], cnt[0]);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (bsy[0] !== 1'b0 || gv[0] !== 1'b0 || cnt[0] !== 16'd0) begin
            failures++;
            $display("FAIL late_done got b=%0b v=%0b c=%0d exp 0 0 0",
                     bsy[0], gv[0], cnt[0]);
        end
    endtask

    task automatic test_random();
        em = 5'h1F; en_mask = 5'h1F; hi_mask = 5'h00;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            em = 5'($urandom & $urandom);
            en_mask = ~5'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0)
                hi_mask = 5'($urandom & $urandom);
            gnt_ack = 1'($urandom_range(0, 1));
            done = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (gv[u] !== (ms[u] == 1) || bsy[u] !== (ms[u] == 2)
                    || cnt[u] !== 16'(mcnt[u])
                    || (ms[u] == 1 && (tag[u] !== 3'(mg[u] + 1)
                        || oh[u] !== 5'(1 << mg[u])))) begin
                    failures++;
                    $display("FAIL rand u%0d cyc%0d got v=%0b b=%0b c=%0d t=%0d oh=%b exp st=%0d c=%0d t=%0d",
                             u, i, gv[u], bsy[u], cnt[u], tag[u], oh[u],
                             ms[u], mcnt[u], mg[u] + 1);
                end
            end
        end
        rst = 1'b0;
        gnt_ack = 1'b0;
        done = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        em = 5'h1F;
        en_mask = 5'h1F;
        hi_mask = 5'h00;
        gnt_ack = 1'b0;
        done = 1'b0;
        checks = 0;
        failures = 0;
        for (int u = 0; u < 2; u++) begin
            ms[u] = 0; mg[u] = 0; mrr[u] = 0;
            mbc[u] = 0; mcnt[u] = 0;
        end
        test_reset();
        test_idle_empty();
        test_rotation();
        test_burst();
        test_hi_class();
        test_mask_in_offer();
        test_ack_done_same();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
